// File: rtl/submultabs_sched_pkg.sv
// rtl/submultabs_sched_pkg.sv - shared state encoding, stream indices and width helper for submultabs_sched
package submultabs_sched_pkg;

  localparam logic STATE_IDLE = 1'b0;
  localparam logic STATE_EMIT = 1'b1;

  typedef enum logic {
    IDLE = STATE_IDLE,
    EMIT = STATE_EMIT
  } state_t;

  localparam int STREAM_DATA  = 0;
  localparam int STREAM_GRID  = 1;
  localparam int STREAM_SCALE = 2;
  localparam int NUM_STREAMS  = 3;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/submultabs_sched_if.sv
// rtl/submultabs_sched_if.sv - input sample stream and the three aligned output streams of submultabs_sched
interface submultabs_sched_if #(
  parameter int DATA_WIDTH_DATA  = 16,
  parameter int DATA_WIDTH_SCALE = 16
);

  logic [DATA_WIDTH_DATA-1:0]  s_axis_x_tdata;
  logic                        s_axis_x_tvalid;
  logic                        s_axis_x_tready;
  logic                        s_axis_x_tlast;

  logic [DATA_WIDTH_DATA-1:0]  m_axis_data_tdata;
  logic                        m_axis_data_tvalid;
  logic                        m_axis_data_tready;
  logic                        m_axis_data_tlast;
  logic                        m_axis_data_tuser;

  logic [DATA_WIDTH_DATA-1:0]  m_axis_grid_tdata;
  logic                        m_axis_grid_tvalid;
  logic                        m_axis_grid_tready;
  logic                        m_axis_grid_tlast;

  logic [DATA_WIDTH_SCALE-1:0] m_axis_scale_tdata;
  logic                        m_axis_scale_tvalid;
  logic                        m_axis_scale_tready;
  logic                        m_axis_scale_tlast;

  // master: the scheduler's view (consumes x, produces the three beat streams)
  modport master (
    input  s_axis_x_tdata, s_axis_x_tvalid, s_axis_x_tlast,
    output s_axis_x_tready,
    output m_axis_data_tdata, m_axis_data_tvalid, m_axis_data_tlast, m_axis_data_tuser,
    input  m_axis_data_tready,
    output m_axis_grid_tdata, m_axis_grid_tvalid, m_axis_grid_tlast,
    input  m_axis_grid_tready,
    output m_axis_scale_tdata, m_axis_scale_tvalid, m_axis_scale_tlast,
    input  m_axis_scale_tready
  );

  modport slave (
    output s_axis_x_tdata, s_axis_x_tvalid, s_axis_x_tlast,
    input  s_axis_x_tready,
    input  m_axis_data_tdata, m_axis_data_tvalid, m_axis_data_tlast, m_axis_data_tuser,
    output m_axis_data_tready,
    input  m_axis_grid_tdata, m_axis_grid_tvalid, m_axis_grid_tlast,
    output m_axis_grid_tready,
    input  m_axis_scale_tdata, m_axis_scale_tvalid, m_axis_scale_tlast,
    output m_axis_scale_tready
  );

endinterface

// File: rtl/submultabs_sched_table.sv
// rtl/submultabs_sched_table.sv - grid/scale register file, one synchronous write port, one asynchronous read port
module submultabs_sched_table #(
  parameter int DATA_WIDTH_DATA  = 16,
  parameter int DATA_WIDTH_SCALE = 16,
  parameter int ADDR_WIDTH       = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [ADDR_WIDTH-1:0]       wr_addr,
  input  logic [DATA_WIDTH_DATA-1:0]  wr_grid,
  input  logic [DATA_WIDTH_SCALE-1:0] wr_scale,
  input  logic [ADDR_WIDTH-1:0]       rd_addr,
  output logic [DATA_WIDTH_DATA-1:0]  rd_grid,
  output logic [DATA_WIDTH_SCALE-1:0] rd_scale
);

  // Full power-of-two depth keeps indexing width-exact; entries past GRID_POINTS are never written.
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH_DATA-1:0]  grid_mem  [DEPTH];
  logic [DATA_WIDTH_SCALE-1:0] scale_mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        grid_mem[i]  <= '0;
        scale_mem[i] <= '0;
      end
    end else if (wr_en) begin
      grid_mem[wr_addr]  <= wr_grid;
      scale_mem[wr_addr] <= wr_scale;
    end
  end

  assign rd_grid  = grid_mem[rd_addr];
  assign rd_scale = scale_mem[rd_addr];

endmodule

// File: rtl/submultabs_sched.sv
// rtl/submultabs_sched.sv - replays each x sample as GRID_POINTS aligned data/grid/scale beats; SUBMULTABS_SCHED_PREFETCH_EN removes the inter-sample bubble
module submultabs_sched
  import submultabs_sched_pkg::*;
#(
  parameter int DATA_WIDTH_DATA  = 16,
  parameter int DATA_WIDTH_SCALE = 16,
  parameter int GRID_POINTS      = 8,
  parameter int ADDR_WIDTH       = idx_width(GRID_POINTS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_wr_en,
  input  logic [ADDR_WIDTH-1:0]       cfg_wr_addr,
  input  logic [DATA_WIDTH_DATA-1:0]  cfg_wr_grid,
  input  logic [DATA_WIDTH_SCALE-1:0] cfg_wr_scale,
  output logic                        cfg_busy,
  output logic                        cfg_err,
  submultabs_sched_if.master          axis
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(GRID_POINTS - 1);
  localparam logic [ADDR_WIDTH:0]   GP_LIMIT  = (ADDR_WIDTH + 1)'(GRID_POINTS);

  state_t                      state_q, state_d;
  logic [ADDR_WIDTH-1:0]       idx_q, idx_d;
  logic [NUM_STREAMS-1:0]      sent_q, sent_d;
  logic [DATA_WIDTH_DATA-1:0]  x_q;
  logic                        x_last_q;
  logic                        cfg_err_q, cfg_err_d;
  logic                        latch_x;

  logic [NUM_STREAMS-1:0]      valid, ready, hs, done;
  logic                        emit, last_beat, beat_done;
  logic                        x_ready, x_hs, wr_ok;
  logic [DATA_WIDTH_DATA-1:0]  rd_grid;
  logic [DATA_WIDTH_SCALE-1:0] rd_scale;

  assign emit      = (state_q == EMIT);
  assign last_beat = (idx_q == LAST_IDX);

  assign ready[STREAM_DATA]  = axis.m_axis_data_tready;
  assign ready[STREAM_GRID]  = axis.m_axis_grid_tready;
  assign ready[STREAM_SCALE] = axis.m_axis_scale_tready;

  // A stream that already handshook this beat stays low-valid until the slowest one catches up.
  assign valid     = {NUM_STREAMS{emit}} & ~sent_q;
  assign hs        = valid & ready;
  assign done      = sent_q | hs;
  assign beat_done = emit && (&done);

`ifdef SUBMULTABS_SCHED_PREFETCH_EN
  assign x_ready = !emit || (beat_done && last_beat);
`else
  assign x_ready = !emit;
`endif

  assign x_hs  = x_ready && axis.s_axis_x_tvalid;
  assign wr_ok = cfg_wr_en && !emit && !x_hs && ({1'b0, cfg_wr_addr} < GP_LIMIT);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sent_d    = sent_q | hs;
    latch_x   = 1'b0;
    cfg_err_d = cfg_err_q | (cfg_wr_en && !wr_ok);
    case (state_q)
      IDLE: begin
        if (x_hs) begin
          latch_x = 1'b1;
          idx_d   = '0;
          sent_d  = '0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (beat_done) begin
          sent_d = '0;
          if (last_beat) begin
            idx_d = '0;
            if (x_hs) begin
              latch_x = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + ADDR_WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      sent_q    <= '0;
      x_q       <= '0;
      x_last_q  <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      sent_q    <= sent_d;
      cfg_err_q <= cfg_err_d;
      if (latch_x) begin
        x_q      <= axis.s_axis_x_tdata;
        x_last_q <= axis.s_axis_x_tlast;
      end
    end
  end

  submultabs_sched_table #(
    .DATA_WIDTH_DATA  (DATA_WIDTH_DATA),
    .DATA_WIDTH_SCALE (DATA_WIDTH_SCALE),
    .ADDR_WIDTH       (ADDR_WIDTH)
  ) u_table (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_ok),
    .wr_addr  (cfg_wr_addr),
    .wr_grid  (cfg_wr_grid),
    .wr_scale (cfg_wr_scale),
    .rd_addr  (idx_q),
    .rd_grid  (rd_grid),
    .rd_scale (rd_scale)
  );

  assign axis.s_axis_x_tready     = x_ready;

  assign axis.m_axis_data_tdata   = x_q;
  assign axis.m_axis_data_tvalid  = valid[STREAM_DATA];
  assign axis.m_axis_data_tlast   = emit && last_beat;
  assign axis.m_axis_data_tuser   = x_last_q;

  assign axis.m_axis_grid_tdata   = rd_grid;
  assign axis.m_axis_grid_tvalid  = valid[STREAM_GRID];
  assign axis.m_axis_grid_tlast   = emit && last_beat;

  assign axis.m_axis_scale_tdata  = rd_scale;
  assign axis.m_axis_scale_tvalid = valid[STREAM_SCALE];
  assign axis.m_axis_scale_tlast  = emit && last_beat;

  assign cfg_busy = emit;
  assign cfg_err  = cfg_err_q;

endmodule
